clk_step_ctrl: RTL and testbench
================================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter DIV_W, default 16, width of the divisor register and of iDiv.
REQ-002 Parameter STEP_W, default 8, width of the step-count input and of the step counter.
REQ-003 iClk  in  1  sole clock; all state updates on the posedge.
REQ-004 iRst  in  1  asynchronous, active-high reset.
REQ-005 iRun  in  1  level; request continuous enable generation.
REQ-006 iHalt  in  1  level; operator stop request.
REQ-007 iCpuHalt  in  1  level; CPU-originated stop request (HALT instruction).
REQ-008 iStep  in  1  one-cycle pulse; start a burst of iStepN enables.
REQ-009 iStepN  in  STEP_W  burst length, sampled with iStep.
REQ-010 iDivLoad  in  1  one-cycle pulse; load iDiv into the divisor register.
REQ-011 iDiv  in  DIV_W  enable period in iClk cycles.
REQ-012 oClkEn  out  1  registered one-cycle CPU clock-enable pulse.
REQ-013 oState  out  2  current state code: 0 HALTED, 1 RUNNING, 2 STEPPING.
REQ-014 oDone  out  1  registered one-cycle pulse when a step burst completes.
REQ-015 oCycles  out  32  count of oClkEn pulses issued.

Function
REQ-016 State machine: HALTED, RUNNING, STEPPING; command priority iHalt > iCpuHalt > iStep > iRun.
REQ-017 HALTED->RUNNING when iRun=1 and no stop request; HALTED->STEPPING on iStep; iRun and iStep are ignored outside HALTED.
REQ-018 RUNNING or STEPPING->HALTED at the same edge that iHalt or iCpuHalt is sampled high; no oClkEn in the following cycle.
REQ-019 Divisor register value 0 is treated as 1; the reset value of the divisor register is 1.
REQ-020 The tick counter is cleared to 0 at every state entry and on iDivLoad; it advances by 1 each cycle only in RUNNING or STEPPING.
REQ-021 When the counter reaches (div-1), the counter returns to 0 and oClkEn is high for exactly the next cycle; with a command sampled at edge k, pulses therefore follow edges k+div, k+2*div, and so on.
REQ-022 div=1 yields oClkEn continuously high while in RUNNING, starting one cycle after entry.
REQ-023 iDivLoad takes effect immediately in any state: the new divisor is latched and the counter is cleared; the first pulse at the new rate follows div cycles later.
REQ-024 On iStep, the burst length is latched from iStepN; iStepN=0 is treated as 1.
REQ-025 STEPPING issues exactly the latched number of pulses, then returns to HALTED on the edge that raises the final oClkEn; oDone is asserted in the same cycle as that final pulse.
REQ-026 A stop request during STEPPING aborts the burst with no oDone pulse.
REQ-027 oCycles increments by 1 on each oClkEn pulse and wraps from 0xFFFFFFFF to 0.

Reset
REQ-028 iRst asynchronously forces HALTED, the tick counter to 0, the divisor register to 1, the step counter to 0, oClkEn=0, oDone=0, oCycles=0 and oState=0.
REQ-029 On iRst deassertion the block stays HALTED until a command is sampled; reset asserted mid-burst discards the burst without an oDone pulse.

Structure
REQ-030 The state codes and the default widths live in the shared package clk_ctrl_pkg.
REQ-031 The divisor register, tick counter and terminal-count compare form the sub-module tick_gen (inputs: enable, clear, load, div; output: tick); the FSM and the counters stay in clk_step_ctrl.

Verification
REQ-032 Scenario 1: reset, iDivLoad with iDiv=4, iRun pulse at edge k -> oClkEn high after edges k+4, k+8 and k+12; oCycles=3 after the third pulse.
REQ-033 Scenario 2: iDiv=0, then iRun -> oClkEn high every cycle from k+1 onward; oState=1 throughout.
REQ-034 Scenario 3: iDiv=2, iStep with iStepN=3 -> exactly 3 pulses at k+2, k+4 and k+6; oDone coincides with the third pulse; oState=0 from edge k+6.
REQ-035 Scenario 4: iStepN=5, iHalt asserted after the 2nd pulse -> no further pulses, no oDone, oState=0 at the next edge.
REQ-036 Scenario 5: iRun and iCpuHalt high together in HALTED -> state remains HALTED and no pulse; iDivLoad with iDiv=3 mid-RUN -> next pulse 3 cycles after the load.
REQ-037 Scenario 6: preload oCycles to 0xFFFFFFFF via force, then one pulse -> oCycles=0; iRst asserted mid-RUN -> every output returns to its reset value immediately, without waiting for an edge.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared state encoding and default widths for the CPU clock-step controller.
package clk_ctrl_pkg;

  localparam int unsigned DefDivW  = 16;
  localparam int unsigned DefStepW = 8;

  typedef enum logic [1:0] {
    StHalted   = 2'd0,
    StRunning  = 2'd1,
    StStepping = 2'd2
  } ctrlState_t;

endpackage

// File: rtl/tick_gen.sv
// Programmable divider: holds the divisor and raises tick for one cycle every div enabled cycles.
module tick_gen
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DefDivW
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] divReg;
  logic [DIV_W-1:0] cnt;

  // divReg is never 0, so divReg-1 is always a valid terminal count
  assign tick = enable && !load && (cnt == (divReg - DIV_W'(1)));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      divReg <= DIV_W'(1);
      cnt    <= '0;
    end else if (load) begin
      divReg <= (div == '0) ? DIV_W'(1) : div;
      cnt    <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable controller: free-run, bounded step bursts and halt handling.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W  = DefDivW,
  parameter int unsigned STEP_W = DefStepW
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iRun,
  input  logic              iHalt,
  input  logic              iCpuHalt,
  input  logic              iStep,
  input  logic [STEP_W-1:0] iStepN,
  input  logic              iDivLoad,
  input  logic [DIV_W-1:0]  iDiv,
  output logic              oClkEn,
  output logic [1:0]        oState,
  output logic              oDone,
  output logic [31:0]       oCycles
);

  ctrlState_t        state;
  ctrlState_t        nextState;
  logic [STEP_W-1:0] stepCnt;
  logic [31:0]       cycles;
  logic              tick;
  logic              stop;
  logic              clkEnNext;
  logic              doneNext;
  logic              stepLoad;
  logic              stateChange;

  assign stop        = iHalt || iCpuHalt;
  assign stateChange = (nextState != state);

  tick_gen #(
    .DIV_W(DIV_W)
  ) uTickGen (
    .iClk   (iClk),
    .iRst   (iRst),
    .enable (state != StHalted),
    .clear  (stateChange),
    .load   (iDivLoad),
    .div    (iDiv),
    .tick   (tick)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= StHalted;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    clkEnNext = 1'b0;
    doneNext  = 1'b0;
    stepLoad  = 1'b0;
    case (state)
      StHalted: begin
        if (!stop) begin
          if (iStep) begin
            nextState = StStepping;
            stepLoad  = 1'b1;
          end else if (iRun) begin
            nextState = StRunning;
          end
        end
      end
      StRunning: begin
        if (stop) nextState = StHalted;
        else      clkEnNext = tick;
      end
      StStepping: begin
        if (stop) begin
          nextState = StHalted;
        end else if (tick) begin
          clkEnNext = 1'b1;
          // final pulse of the burst leaves STEPPING on the same edge
          if (stepCnt == STEP_W'(1)) begin
            doneNext  = 1'b1;
            nextState = StHalted;
          end
        end
      end
      default: nextState = StHalted;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stepCnt <= '0;
      oClkEn  <= 1'b0;
      oDone   <= 1'b0;
      cycles  <= '0;
    end else begin
      oClkEn <= clkEnNext;
      oDone  <= doneNext;
      if (clkEnNext) cycles <= cycles + 32'd1;
      if (stepLoad) begin
        stepCnt <= (iStepN == '0) ? STEP_W'(1) : iStepN;
      end else if (clkEnNext && (state == StStepping)) begin
        stepCnt <= stepCnt - STEP_W'(1);
      end
    end
  end

  assign oState  = state;
  assign oCycles = cycles;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed, table-driven bench for clk_step_ctrl with hand-written reset/wrap sequences.
module tb_clk_step_ctrl;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iRun, iHalt, iCpuHalt, iStep, iDivLoad;
  logic [7:0]  iStepN;
  logic [15:0] iDiv;
  logic        oClkEn, oDone;
  logic [1:0]  oState;
  logic [31:0] oCycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        run, halt, cpuHalt, step;
    logic [7:0]  stepN;
    logic        divLoad;
    logic [15:0] div;
    logic        expClkEn;
    logic [1:0]  expState;
    logic        expDone;
    logic [31:0] expCycles;
  } vec_t;

  vec_t vecs[$];

  clk_step_ctrl #(.DIV_W(16), .STEP_W(8)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iRun     (iRun),
    .iHalt    (iHalt),
    .iCpuHalt (iCpuHalt),
    .iStep    (iStep),
    .iStepN   (iStepN),
    .iDivLoad (iDivLoad),
    .iDiv     (iDiv),
    .oClkEn   (oClkEn),
    .oState   (oState),
    .oDone    (oDone),
    .oCycles  (oCycles)
  );

  always #5 iClk = ~iClk;

  function automatic void add(input int rep, input logic run, input logic halt,
                              input logic cpuHalt, input logic step, input logic [7:0] stepN,
                              input logic divLoad, input logic [15:0] div,
                              input logic eClk, input logic [1:0] eSt, input logic eDone,
                              input logic [31:0] eCyc);
    vec_t v;
    v.run = run; v.halt = halt; v.cpuHalt = cpuHalt; v.step = step; v.stepN = stepN;
    v.divLoad = divLoad; v.div = div;
    v.expClkEn = eClk; v.expState = eSt; v.expDone = eDone; v.expCycles = eCyc;
    for (int i = 0; i < rep; i++) vecs.push_back(v);
  endfunction

  function automatic void idle(input int rep, input logic eClk, input logic [1:0] eSt,
                               input logic eDone, input logic [31:0] eCyc);
    add(rep, 0, 0, 0, 0, 8'd0, 0, 16'd0, eClk, eSt, eDone, eCyc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    // Scenario 1: div=4 run
    add(1, 0, 0, 0, 0, 8'd0, 1, 16'd4, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 8'd0, 0, 16'd0, 0, 1, 0, 0);
    idle(3, 0, 1, 0, 0);  idle(1, 1, 1, 0, 1);
    idle(3, 0, 1, 0, 1);  idle(1, 1, 1, 0, 2);
    idle(3, 0, 1, 0, 2);  idle(1, 1, 1, 0, 3);
    add(1, 0, 1, 0, 0, 8'd0, 0, 16'd0, 0, 0, 0, 3);
    // Scenario 2: div=0 behaves as 1; halt suppresses the pending pulse
    add(1, 0, 0, 0, 0, 8'd0, 1, 16'd0, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 8'd0, 0, 16'd0, 0, 1, 0, 3);
    for (int i = 0; i < 5; i++) idle(1, 1, 1, 0, 32'(4 + i));
    add(1, 0, 1, 0, 0, 8'd0, 0, 16'd0, 0, 0, 0, 8);
    // Scenario 3: div=2, burst of 3, then burst length 0 treated as 1
    add(1, 0, 0, 0, 0, 8'd0, 1, 16'd2, 0, 0, 0, 8);
    add(1, 0, 0, 0, 1, 8'd3, 0, 16'd0, 0, 2, 0, 8);
    idle(1, 0, 2, 0, 8);  idle(1, 1, 2, 0, 9);
    idle(1, 0, 2, 0, 9);  idle(1, 1, 2, 0, 10);
    idle(1, 0, 2, 0, 10); idle(1, 1, 0, 1, 11);
    idle(1, 0, 0, 0, 11);
    add(1, 0, 0, 0, 1, 8'd0, 0, 16'd0, 0, 2, 0, 11);
    idle(1, 0, 2, 0, 11); idle(1, 1, 0, 1, 12);
    idle(1, 0, 0, 0, 12);
    // Scenario 4: burst of 5 aborted by halt after the 2nd pulse
    add(1, 0, 0, 0, 1, 8'd5, 0, 16'd0, 0, 2, 0, 12);
    idle(1, 0, 2, 0, 12); idle(1, 1, 2, 0, 13);
    idle(1, 0, 2, 0, 13); idle(1, 1, 2, 0, 14);
    add(1, 0, 1, 0, 0, 8'd0, 0, 16'd0, 0, 0, 0, 14);
    idle(4, 0, 0, 0, 14);
    // Scenario 5: cpu halt beats run; divisor reload mid-run; step ignored while running
    add(1, 1, 0, 1, 0, 8'd0, 0, 16'd0, 0, 0, 0, 14);
    idle(2, 0, 0, 0, 14);
    add(1, 1, 0, 0, 0, 8'd0, 0, 16'd0, 0, 1, 0, 14);
    idle(1, 0, 1, 0, 14); idle(1, 1, 1, 0, 15);
    idle(1, 0, 1, 0, 15);
    add(1, 0, 0, 0, 0, 8'd0, 1, 16'd3, 0, 1, 0, 15);
    idle(2, 0, 1, 0, 15); idle(1, 1, 1, 0, 16);
    add(1, 0, 0, 0, 1, 8'd1, 0, 16'd0, 0, 1, 0, 16);
    add(1, 0, 1, 0, 0, 8'd0, 0, 16'd0, 0, 0, 0, 16);

    iRst = 1'b1; iRun = 0; iHalt = 0; iCpuHalt = 0; iStep = 0; iStepN = '0;
    iDivLoad = 0; iDiv = '0;
    cyc(); cyc();
    chk("rst.clkEn", 32'(oClkEn), 0);
    chk("rst.state", 32'(oState), 0);
    chk("rst.done", 32'(oDone), 0);
    chk("rst.cycles", oCycles, 0);
    iRst = 1'b0;
    cyc();
    chk("postrst.state", 32'(oState), 0);

    foreach (vecs[i]) begin
      iRun = vecs[i].run; iHalt = vecs[i].halt; iCpuHalt = vecs[i].cpuHalt;
      iStep = vecs[i].step; iStepN = vecs[i].stepN;
      iDivLoad = vecs[i].divLoad; iDiv = vecs[i].div;
      cyc();
      chk($sformatf("vec%0d.clkEn", i), 32'(oClkEn), 32'(vecs[i].expClkEn));
      chk($sformatf("vec%0d.state", i), 32'(oState), 32'(vecs[i].expState));
      chk($sformatf("vec%0d.done", i), 32'(oDone), 32'(vecs[i].expDone));
      chk($sformatf("vec%0d.cycles", i), oCycles, vecs[i].expCycles);
    end
    iRun = 0; iHalt = 0; iCpuHalt = 0; iStep = 0; iDivLoad = 0;

    // Scenario 6a: pulse counter wraps (divisor is 3 here)
    force dut.cycles = 32'hFFFF_FFFF;
    #1;
    release dut.cycles;
    iStep = 1; iStepN = 8'd1;
    cyc();
    iStep = 0;
    chk("wrap.state", 32'(oState), 2);
    cyc(); cyc(); cyc();
    chk("wrap.clkEn", 32'(oClkEn), 1);
    chk("wrap.done", 32'(oDone), 1);
    chk("wrap.cycles", oCycles, 0);

    // Scenario 6b: asynchronous reset while oClkEn is high
    iDivLoad = 1; iDiv = 16'd2;
    cyc();
    iDivLoad = 0; iRun = 1;
    cyc();
    iRun = 0;
    cyc(); cyc();
    chk("prerst.clkEn", 32'(oClkEn), 1);
    chk("prerst.cycles", oCycles, 1);
    #2 iRst = 1'b1;
    #1;
    chk("arst.clkEn", 32'(oClkEn), 0);
    chk("arst.state", 32'(oState), 0);
    chk("arst.done", 32'(oDone), 0);
    chk("arst.cycles", oCycles, 0);
    cyc();
    iRst = 1'b0;
    cyc(); cyc(); cyc();
    chk("idle.state", 32'(oState), 0);
    chk("idle.clkEn", 32'(oClkEn), 0);
    iRun = 1;
    cyc();
    iRun = 0;
    chk("rerun.clkEn0", 32'(oClkEn), 0);
    cyc();
    chk("rerun.clkEn1", 32'(oClkEn), 1);
    chk("rerun.cycles", oCycles, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
